mca_sched: RTL and testbench

Sequencer for the multi-clock-adder FIR datapath. It collects incoming N-bit control vectors into a K-deep window and decimates by DOWNSAMPLE. On each decimation point it freezes a snapshot of the window, pulses `adder_start` into the hierarchical adder, and waits the adder's fixed latency. It then captures the result and presents it with a one-cycle valid. It sits between the CBADC control-bit input stream and the hierarchical adder, and applies backpressure when a new decimation point arrives before the previous computation has finished.

---
 rtl/mca_sched_pkg.sv | 15 +
 rtl/mca_window_sr.sv | 50 +++++
 rtl/mca_sched.sv | 137 +++++++++++++
 tb/tb_mca_sched.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mca_sched_pkg.sv
// Shared types and width helpers for the mca_sched sequencer.
package mca_sched_pkg;

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    IDLE    = 2'd1,
    COMPUTE = 2'd2
  } mca_sched_state_t;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mca_window_sr.sv
// K-deep shift register of N-bit control vectors plus a frozen snapshot copy.
module mca_window_sr #(
  parameter int K = 256,
  parameter int N = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                shift_en,
  input  logic [N-1:0]        s_in,
  input  logic                snap_load,
  output logic [K-1:0][N-1:0] snap
);

  logic [K-1:0][N-1:0] win_q;
  logic [K-1:0][N-1:0] win_d;
  logic [K-1:0][N-1:0] snap_q;
  logic [K-1:0][N-1:0] snap_d;

  // Shift the live window; the snapshot takes the post-shift contents.
  always_comb begin
    win_d = win_q;
    if (shift_en) begin
      win_d[0] = s_in;
      for (int k = 1; k < K; k++) begin
        win_d[k] = win_q[k-1];
      end
    end else begin
      win_d = win_q;
    end
    if (snap_load) begin
      snap_d = win_d;
    end else begin
      snap_d = snap_q;
    end
  end

  // Window and snapshot registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      win_q  <= '0;
      snap_q <= '0;
    end else begin
      win_q  <= win_d;
      snap_q <= snap_d;
    end
  end

  assign snap = snap_q;

endmodule

// File: rtl/mca_sched.sv
// Window fill / decimation sequencer driving the hierarchical adder and
// registering its result as the decimated output sample.
module mca_sched
  import mca_sched_pkg::*;
#(
  parameter int K                 = 256,
  parameter int N                 = 8,
  parameter int WIDTH_COEFFICIENT = 32,
  parameter int DOWNSAMPLE        = 4,
  parameter int ADDER_LATENCY     = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                enable,
  input  logic [N-1:0]                        s_in,
  input  logic                                s_valid,
  output logic                                s_ready,
  output logic [K-1:0][N-1:0]                 S_matrix,
  output logic                                adder_start,
  input  logic [WIDTH_COEFFICIENT-1:0]        adder_sample,
  output logic signed [WIDTH_COEFFICIENT-1:0] out_sample,
  output logic                                out_valid
);

  localparam int FILL_W = cnt_width(K + 1);
  localparam int DS_W   = cnt_width(DOWNSAMPLE);
  localparam int LAT_W  = cnt_width(ADDER_LATENCY + 1);

  localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(K);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(K - 1);
  localparam logic [DS_W-1:0]   DS_LAST   = DS_W'(DOWNSAMPLE - 1);
  localparam logic [LAT_W-1:0]  LAT_MAX   = LAT_W'(ADDER_LATENCY);

  mca_sched_state_t                    state_q, state_d;
  logic [FILL_W-1:0]                   fill_cnt_q, fill_cnt_d;
  logic [DS_W-1:0]                     ds_cnt_q, ds_cnt_d;
  logic [LAT_W-1:0]                    lat_cnt_q, lat_cnt_d;
  logic                                adder_start_q, adder_start_d;
  logic                                out_valid_q, out_valid_d;
  logic signed [WIDTH_COEFFICIENT-1:0] out_sample_q, out_sample_d;

  logic fill_done_s;
  logic ds_last_s;
  logic s_ready_s;
  logic accept_s;
  logic trigger_s;

  // Handshake, trigger detection and next-state computation.
  always_comb begin
    fill_done_s = (fill_cnt_q == FILL_MAX);
    ds_last_s   = (ds_cnt_q == DS_LAST);
    // Hold off the next trigger while the adder is still busy.
    s_ready_s   = enable && !reset && !((state_q == COMPUTE) && fill_done_s && ds_last_s);
    accept_s    = s_valid && s_ready_s;
    trigger_s   = accept_s && (fill_done_s ? ds_last_s : (fill_cnt_q == FILL_LAST));

    if (accept_s && !fill_done_s) begin
      fill_cnt_d = fill_cnt_q + FILL_W'(1);
    end else begin
      fill_cnt_d = fill_cnt_q;
    end

    if (accept_s && fill_done_s) begin
      ds_cnt_d = ds_last_s ? '0 : ds_cnt_q + DS_W'(1);
    end else begin
      ds_cnt_d = ds_cnt_q;
    end

    state_d       = state_q;
    lat_cnt_d     = lat_cnt_q;
    out_valid_d   = 1'b0;
    out_sample_d  = out_sample_q;
    adder_start_d = trigger_s;

    case (state_q)
      FILL, IDLE: begin
        if (trigger_s) begin
          state_d   = COMPUTE;
          lat_cnt_d = '0;
        end else begin
          state_d   = state_q;
        end
      end
      COMPUTE: begin
        if (lat_cnt_q == LAT_MAX) begin
          state_d      = IDLE;
          out_valid_d  = 1'b1;
          out_sample_d = $signed(adder_sample);
        end else begin
          lat_cnt_d    = lat_cnt_q + LAT_W'(1);
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= FILL;
      fill_cnt_q    <= '0;
      ds_cnt_q      <= '0;
      lat_cnt_q     <= '0;
      adder_start_q <= 1'b0;
      out_valid_q   <= 1'b0;
      out_sample_q  <= '0;
    end else begin
      state_q       <= state_d;
      fill_cnt_q    <= fill_cnt_d;
      ds_cnt_q      <= ds_cnt_d;
      lat_cnt_q     <= lat_cnt_d;
      adder_start_q <= adder_start_d;
      out_valid_q   <= out_valid_d;
      out_sample_q  <= out_sample_d;
    end
  end

  mca_window_sr #(
    .K (K),
    .N (N)
  ) u_window (
    .clk       (clk),
    .reset     (reset),
    .shift_en  (accept_s),
    .s_in      (s_in),
    .snap_load (trigger_s),
    .snap      (S_matrix)
  );

  assign s_ready     = s_ready_s;
  assign adder_start = adder_start_q;
  assign out_valid   = out_valid_q;
  assign out_sample  = out_sample_q;

endmodule

// File: tb/tb_mca_sched.sv
// Randomized bench for mca_sched: a history-queue reference model predicts
// handshake, trigger timing, snapshots and captured adder results each cycle.
module tb_mca_sched;

  localparam int K  = 8;
  localparam int N  = 3;
  localparam int W  = 16;
  localparam int DS = 4;
  localparam int L  = 5;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                en = 1'b0;
  logic                sv = 1'b0;
  logic [N-1:0]        sin = '0;
  logic                s_rdy;
  logic [K-1:0][N-1:0] smat;
  logic                start;
  logic [W-1:0]        asamp = '0;
  logic signed [W-1:0] osamp;
  logic                ovalid;

  logic                b_rst = 1'b1;
  logic                b_en = 1'b0;
  logic                b_sv = 1'b0;
  logic [N-1:0]        b_sin = '0;
  logic                b_s_rdy;
  logic [K-1:0][N-1:0] b_smat;
  logic                b_start;
  logic [W-1:0]        b_asamp = '0;
  logic signed [W-1:0] b_osamp;
  logic                b_ovalid;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  int                  c = 0;
  int                  acc_n = 0;
  int                  trig_c = -1;
  logic [N-1:0]        hist[$];
  logic                exp_start = 1'b0;
  logic                exp_valid = 1'b0;
  logic [W-1:0]        exp_sample = '0;
  logic [K-1:0][N-1:0] exp_smat = '0;
  bit                  primed = 1'b0;
  logic [W-1:0]        b_hist[100];

  // Free-running clock.
  always #5 clk = ~clk;

  mca_sched #(
    .K(K), .N(N), .WIDTH_COEFFICIENT(W), .DOWNSAMPLE(DS), .ADDER_LATENCY(L)
  ) dut_a (
    .clk(clk), .reset(rst), .enable(en), .s_in(sin), .s_valid(sv),
    .s_ready(s_rdy), .S_matrix(smat), .adder_start(start),
    .adder_sample(asamp), .out_sample(osamp), .out_valid(ovalid)
  );

  mca_sched #(
    .K(K), .N(N), .WIDTH_COEFFICIENT(W), .DOWNSAMPLE(8), .ADDER_LATENCY(2)
  ) dut_b (
    .clk(clk), .reset(b_rst), .enable(b_en), .s_in(b_sin), .s_valid(b_sv),
    .s_ready(b_s_rdy), .S_matrix(b_smat), .adder_start(b_start),
    .adder_sample(b_asamp), .out_sample(b_osamp), .out_valid(b_ovalid)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, c);
    end
  endtask

  // n-th accept (1-based) triggers when it fills the window or completes a decimation period.
  function automatic bit is_trig(input int n);
    return (n == K) || (n > K && ((n - K) % DS) == 0);
  endfunction

  function automatic bit in_compute(input int cyc);
    return (trig_c >= 0) && (cyc >= trig_c + 1) && (cyc <= trig_c + 1 + L);
  endfunction

  task automatic step(input logic r, input logic e, input logic v, input logic [N-1:0] d);
    logic         exp_ready;
    logic [W-1:0] a;
    @(negedge clk);
    a     = W'($urandom);
    rst   = r;
    en    = e;
    sv    = v;
    sin   = d;
    asamp = a;
    #1;
    if (primed) begin
      check_val("adder_start", start, exp_start);
      check_val("out_valid", ovalid, exp_valid);
      check_val("out_sample", $unsigned(osamp), exp_sample);
      check_val("S_matrix", smat, exp_smat);
    end
    exp_ready = !r && e && !(in_compute(c) && acc_n >= K && is_trig(acc_n + 1));
    check_val("s_ready", s_rdy, exp_ready);
    if (r) begin
      hist.delete();
      acc_n      = 0;
      trig_c     = -1;
      exp_start  = 1'b0;
      exp_valid  = 1'b0;
      exp_sample = '0;
      exp_smat   = '0;
      primed     = 1'b1;
    end else begin
      exp_valid = (trig_c >= 0) && (c == trig_c + 1 + L);
      if (exp_valid) exp_sample = a;
      exp_start = 1'b0;
      if (exp_ready && v) begin
        hist.push_front(d);
        if (hist.size() > K) void'(hist.pop_back());
        acc_n++;
        if (is_trig(acc_n)) begin
          trig_c    = c;
          exp_start = 1'b1;
          for (int k = 0; k < K; k++) exp_smat[k] = hist[k];
        end
      end
    end
    c++;
  endtask

  // Bound the whole run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Main stimulus sequence.
  initial begin
    int  n;
    logic expv;

    repeat (3) step(1'b1, 1'b1, 1'b1, '0);

    for (int i = 1; i <= 40; i++) step(1'b0, 1'b1, 1'b1, N'(i));

    n = 0;
    while (!(trig_c >= 0 && c == trig_c + 2) && n < 50) begin
      step(1'b0, 1'b1, 1'b1, N'($urandom));
      n++;
    end
    check_val("gap_reached", 64'(n < 50), 64'(1));
    repeat (10) step(1'b0, 1'b0, 1'b1, N'($urandom));
    repeat (20) step(1'b0, 1'b1, 1'b1, N'($urandom));

    n = 0;
    while (!(trig_c >= 0 && c == trig_c + 3) && n < 50) begin
      step(1'b0, 1'b1, 1'b1, N'($urandom));
      n++;
    end
    check_val("rst_reached", 64'(n < 50), 64'(1));
    step(1'b1, 1'b1, 1'b1, N'($urandom));
    repeat (30) step(1'b0, 1'b1, 1'b1, N'($urandom));

    repeat (600) step(1'b0, 1'(($urandom % 8) != 0), 1'($urandom % 2), N'($urandom));

    // Second configuration: latency short enough that backpressure never appears.
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      b_rst      = 1'b0;
      b_en       = 1'b1;
      b_sv       = 1'b1;
      b_sin      = N'($urandom);
      b_hist[i]  = W'($urandom);
      b_asamp    = b_hist[i];
      #1;
      check_val("b_s_ready", b_s_rdy, 1'b1);
      expv = (i >= 11) && (((i - 11) % 8) == 0);
      check_val("b_out_valid", b_ovalid, expv);
      if (expv) check_val("b_out_sample", $unsigned(b_osamp), b_hist[i-1]);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
